// File: rtl/tx_serializer_pkg.sv
// tx_serializer_pkg: shared PHY constants and serializer state type
package tx_serializer_pkg;

  localparam int SYMBOL_WIDTH = 10;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_e;

  // K28.5 comma symbols for both running disparities
  localparam logic [9:0] K285_RDN = 10'b0101111100;
  localparam logic [9:0] K285_RDP = 10'b1010000011;

endpackage

// File: rtl/tx_serializer.sv
// tx_serializer: parallel-to-serial symbol transmitter with a one-symbol skid buffer
module tx_serializer
  import tx_serializer_pkg::*;
#(
  parameter int   WIDTH      = SYMBOL_WIDTH,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             Bit_Rate_Clk,
  input  logic             Rst,
  input  logic             Enable,
  input  logic [WIDTH-1:0] Data_10,
  input  logic             Data_Valid,
  output logic             Data_Ready,
  output logic             TX_Out,
  output logic             TX_Active,
  output logic             Word_Strobe
);

  ser_state_e       state, state_d;
  logic [WIDTH-1:0] hold_q, shift_q, shift_nx;
  logic [3:0]       bit_cnt;
  logic             hold_valid, last, load, shift, capture;

  // bit that leaves the shifter first for the configured order
  function automatic logic head(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  // ready comes straight from a flop, so no valid-to-ready combinational path
  assign Data_Ready = ~hold_valid;

  // next-state decision: reload on an empty shifter or the final bit, else keep shifting
  always_comb begin
    last     = bit_cnt == 4'(WIDTH-1);
    load     = hold_valid & (state == IDLE | last);
    shift    = state == SHIFT & ~last;
    capture  = Data_Valid & ~hold_valid & Enable;
    shift_nx = LSB_FIRST ? shift_q >> 1 : shift_q << 1;
    state_d  = load | shift ? SHIFT : IDLE;
  end

  // state register
  always_ff @(posedge Bit_Rate_Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_d;
  end

  // skid buffer, shifter, bit counter and registered serial outputs
  always_ff @(posedge Bit_Rate_Clk or negedge Rst) begin
    if (!Rst) begin
      hold_q      <= '0;
      hold_valid  <= 1'b0;
      shift_q     <= '0;
      bit_cnt     <= '0;
      Word_Strobe <= 1'b0;
      TX_Active   <= 1'b0;
      TX_Out      <= IDLE_LEVEL;
    end else begin
      if (capture) hold_q <= Data_10;
      hold_valid  <= capture | (hold_valid & ~load);
      shift_q     <= load ? hold_q : shift ? shift_nx : shift_q;
      bit_cnt     <= load ? '0 : shift ? bit_cnt + 4'd1 : bit_cnt;
      Word_Strobe <= load;
      TX_Active   <= load | shift;
      TX_Out      <= load ? head(hold_q) : shift ? head(shift_nx) : IDLE_LEVEL;
    end
  end

endmodule

// File: doc/tx_serializer.md
Name: tx_serializer

Overview:
Parallel-to-serial (PISO) transmit stage directly downstream of the 8b/10b encoder. It accepts 10-bit symbols (Data_10) through a valid/ready handshake and shifts them out one bit per Bit_Rate_Clk cycle, back-to-back with no gaps. It emits a one-cycle Word_Strobe per loaded symbol; upstream uses this as its symbol-rate enable. When it has no data it drives a defined idle level.

Parameters:
WIDTH, 10, symbol width in bits
LSB_FIRST, 1, 1 = shift out Data_10[0] (bit 'a') first; 0 = Data_10[WIDTH-1] first
IDLE_LEVEL, 0, TX_Out value while not transmitting

Ports:
Bit_Rate_Clk  in   1      serial bit clock; the only clock
Rst           in   1      asynchronous, active-low reset
Enable        in   1      serializer enable (from MAC_Data_En)
Data_10       in   WIDTH  encoded symbol from the encoder
Data_Valid    in   1      Data_10 is valid this cycle
Data_Ready    out  1      holding register empty; a symbol is accepted when Data_Valid & Data_Ready & Enable
TX_Out        out  1      serial bit, registered
TX_Active     out  1      TX_Out carries symbol bits this cycle
Word_Strobe   out  1      one-cycle pulse on the cycle the first bit of a symbol appears on TX_Out

Behaviour:
- Clock and reset: one clock, Bit_Rate_Clk. Rst is asynchronous and active-low.
- Reset values, Rst=0 asynchronously: TX_Out=IDLE_LEVEL, TX_Active=0, Word_Strobe=0, Data_Ready=1, state=IDLE, bit_cnt=0, hold_valid=0, shift_q=0.
- Storage:
  - hold_q[WIDTH-1:0] plus hold_valid (one-symbol skid buffer).
  - shift_q[WIDTH-1:0] and bit_cnt[3:0], counting 0..WIDTH-1.
- Data_Ready = ~hold_valid, registered. There is no combinational path from Data_Valid to Data_Ready.
- Capture: on an edge where Data_Valid & Data_Ready & Enable: hold_q <= Data_10, hold_valid <= 1. Data_Valid with Enable=0 is ignored.
- Load event ("load"): shift_q <= hold_q, hold_valid <= 0, bit_cnt <= 0, Word_Strobe <= 1, TX_Active <= 1, TX_Out <= first bit of hold_q.
  - A load and a capture never occur on the same edge, because Ready is low while hold_valid=1.
- State machine, 2 states:
  - IDLE:
    - hold_valid=1 -> load, go to SHIFT.
    - Otherwise TX_Out=IDLE_LEVEL, TX_Active=0.
  - SHIFT:
    - bit_cnt<WIDTH-1: shift by one position toward the output end, bit_cnt++, TX_Out <= next bit, Word_Strobe <= 0.
    - bit_cnt==WIDTH-1 and hold_valid=1: load again. Output is continuous with no idle bit.
    - bit_cnt==WIDTH-1 and hold_valid=0: go to IDLE, TX_Active <= 0, TX_Out <= IDLE_LEVEL.
- Latency: symbol accepted at edge E0; hold at E0; first bit on TX_Out after E1; last bit after E(WIDTH). Two symbols presented consecutively are serialized with zero gap.
- Enable deasserted mid-symbol: the current shift and any already-held symbol complete. No new captures; then IDLE. Symbols are never truncated.
- Reset mid-symbol: immediate abort and all reset values apply. A held symbol is discarded.
- Throughput: at most one symbol per WIDTH cycles. Upstream must gate by Word_Strobe or Data_Ready. Data_Valid while Ready=0 is held off; the data is not lost or overwritten.
- Bit order:
  - LSB_FIRST=1: output order Data_10[0], [1], ..., [WIDTH-1].
  - LSB_FIRST=0: reversed.
- Word_Strobe is high for exactly 1 cycle per load, coincident with the first serial bit.

Decomposition:
- Shared PHY package holds:
  - SYMBOL_WIDTH=10.
  - Serializer state enum {IDLE, SHIFT}.
  - K28.5 constants K285_RDN=10'b0101111100 and K285_RDP=10'b1010000011, for benches and idle fill.
- No sub-module. Holding register, counter and shift register are all in one module, well within 120-400 lines.

Test Plan:
- Reset: hold Rst=0 over several cycles, then release -> TX_Out=0, TX_Active=0, Data_Ready=1, Word_Strobe=0 throughout.
- Single symbol: Data_10=10'b0101111100 with Data_Valid=1 for 1 cycle -> after one cycle TX_Out = 0,0,1,1,1,1,1,0,1,0. TX_Active high for exactly 10 cycles, Word_Strobe high on the first of them, then idle 0.
- Back-to-back: 0x17C, then 0x283, then 0x0F5 presented whenever Ready=1 -> 30 contiguous serial bits with no gap. Word_Strobe fires every 10 cycles exactly 3 times; TX_Active never drops.
- Backpressure: Data_Valid held high with changing data while Ready=0 -> only values sampled while Ready=1 appear serialized. No overwrite of hold_q.
- Enable drop: deassert Enable at bit 4 of a symbol with another symbol already held -> both symbols complete (20 bits), then idle. A Data_Valid presented afterward is not accepted.
- Mid-symbol reset: assert Rst at bit 6 -> TX_Out=IDLE_LEVEL and TX_Active=0 immediately (asynchronous). After release the held symbol is not transmitted.
- LSB_FIRST=0 with 10'b0101111100 -> serial output 0,1,0,1,1,1,1,1,0,0.
